// File: rtl/rs_multi_cdb.sv
// Reservation station with multi-port CDB wakeup, alloc-cycle bypass and
// age-matrix oldest-ready selection.
module rs_multi_cdb #(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TAG_W       = 5,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned PAYLOAD_W   = 64,
    parameter int unsigned NUM_CDB     = 2,
    parameter int unsigned NO_WAIT_RS2 = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alloc_valid,
    output logic                          alloc_ready,
    input  logic [TAG_W-1:0]              alloc_rd_tag,
    input  logic [TAG_W-1:0]              alloc_rs1_tag,
    input  logic [TAG_W-1:0]              alloc_rs2_tag,
    input  logic                          alloc_rs1_rdy,
    input  logic                          alloc_rs2_rdy,
    input  logic [DATA_W-1:0]             alloc_rs1_val,
    input  logic [DATA_W-1:0]             alloc_rs2_val,
    input  logic [PAYLOAD_W-1:0]          alloc_payload,
    input  logic [NUM_CDB-1:0]            cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]     cdb_value,
    output logic                          issue_valid,
    input  logic                          issue_ready,
    output logic [TAG_W-1:0]              issue_rd_tag,
    output logic [DATA_W-1:0]             issue_rs1_val,
    output logic [DATA_W-1:0]             issue_rs2_val,
    output logic [PAYLOAD_W-1:0]          issue_payload,
    input  logic                          flush,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [DEPTH-1:0]     rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0]     rs2_rdy_q, rs2_rdy_d;
    logic [TAG_W-1:0]     rd_tag_q  [DEPTH];
    logic [TAG_W-1:0]     rd_tag_d  [DEPTH];
    logic [TAG_W-1:0]     rs1_tag_q [DEPTH];
    logic [TAG_W-1:0]     rs1_tag_d [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_q [DEPTH];
    logic [TAG_W-1:0]     rs2_tag_d [DEPTH];
    logic [DATA_W-1:0]    rs1_val_q [DEPTH];
    logic [DATA_W-1:0]    rs1_val_d [DEPTH];
    logic [DATA_W-1:0]    rs2_val_q [DEPTH];
    logic [DATA_W-1:0]    rs2_val_d [DEPTH];
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    // older_q[i][j] set means entry i was allocated before entry j
    logic [DEPTH-1:0]     older_q   [DEPTH];
    logic [DEPTH-1:0]     older_d   [DEPTH];
    logic [CNT_W-1:0]     count_q, count_d;

    logic [DEPTH-1:0]     issuable;
    logic [IDX_W-1:0]     sel_idx;
    logic [IDX_W-1:0]     free_idx;
    logic                 any_issuable;
    logic                 blocked;
    logic                 free_found;
    logic                 issue_fire;
    logic                 alloc_fire;
    logic [DATA_W:0]      lk1, lk2;

    // Returns {hit, value}; the lowest-index matching port wins.
    function automatic logic [DATA_W:0] cdb_lookup(
        input logic [TAG_W-1:0]          tag,
        input logic [NUM_CDB-1:0]        vld,
        input logic [NUM_CDB*TAG_W-1:0]  tags,
        input logic [NUM_CDB*DATA_W-1:0] vals
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int unsigned p = 0; p < NUM_CDB; p++) begin
            if (!res[DATA_W] && vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
                res = {1'b1, vals[p*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            issuable[i] = valid_q[i] && rs1_rdy_q[i] && (rs2_rdy_q[i] || (NO_WAIT_RS2 != 0));
        end
    end

    always_comb begin
        sel_idx      = '0;
        blocked      = 1'b0;
        any_issuable = |issuable;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if (issuable[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (issuable[i] && !blocked) sel_idx = IDX_W'(i);
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign alloc_ready   = (count_q < CNT_W'(DEPTH)) && !reset;
    assign issue_valid   = any_issuable && !flush && !reset;
    assign issue_fire    = issue_valid && issue_ready;
    assign alloc_fire    = alloc_valid && alloc_ready && !flush;
    assign issue_rd_tag  = rd_tag_q[sel_idx];
    assign issue_rs1_val = rs1_val_q[sel_idx];
    assign issue_rs2_val = rs2_val_q[sel_idx];
    assign issue_payload = payload_q[sel_idx];
    assign count         = count_q;

    always_comb begin
        valid_d   = valid_q;
        rs1_rdy_d = rs1_rdy_q;
        rs2_rdy_d = rs2_rdy_q;
        rd_tag_d  = rd_tag_q;
        rs1_tag_d = rs1_tag_q;
        rs2_tag_d = rs2_tag_q;
        rs1_val_d = rs1_val_q;
        rs2_val_d = rs2_val_q;
        payload_d = payload_q;
        older_d   = older_q;
        lk1       = '0;
        lk2       = '0;
        count_d   = '0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                lk1 = cdb_lookup(rs1_tag_q[i], cdb_valid, cdb_tag, cdb_value);
                lk2 = cdb_lookup(rs2_tag_q[i], cdb_valid, cdb_tag, cdb_value);
                if (!rs1_rdy_q[i] && lk1[DATA_W]) begin
                    rs1_rdy_d[i] = 1'b1;
                    rs1_val_d[i] = lk1[DATA_W-1:0];
                end
                if (!rs2_rdy_q[i] && lk2[DATA_W]) begin
                    rs2_rdy_d[i] = 1'b1;
                    rs2_val_d[i] = lk2[DATA_W-1:0];
                end
            end
        end

        if (issue_fire) valid_d[sel_idx] = 1'b0;

        // free_idx comes from registered valid, so it never aliases the slot issuing now
        if (alloc_fire) begin
            lk1 = cdb_lookup(alloc_rs1_tag, cdb_valid, cdb_tag, cdb_value);
            lk2 = cdb_lookup(alloc_rs2_tag, cdb_valid, cdb_tag, cdb_value);
            valid_d[free_idx]   = 1'b1;
            rd_tag_d[free_idx]  = alloc_rd_tag;
            rs1_tag_d[free_idx] = alloc_rs1_tag;
            rs2_tag_d[free_idx] = alloc_rs2_tag;
            payload_d[free_idx] = alloc_payload;
            rs1_rdy_d[free_idx] = alloc_rs1_rdy || (alloc_rs1_tag == '0) || lk1[DATA_W];
            rs2_rdy_d[free_idx] = alloc_rs2_rdy || (alloc_rs2_tag == '0) || lk2[DATA_W];
            rs1_val_d[free_idx] = (!alloc_rs1_rdy && (alloc_rs1_tag != '0) && lk1[DATA_W])
                                  ? lk1[DATA_W-1:0] : alloc_rs1_val;
            rs2_val_d[free_idx] = (!alloc_rs2_rdy && (alloc_rs2_tag != '0) && lk2[DATA_W])
                                  ? lk2[DATA_W-1:0] : alloc_rs2_val;
            for (int unsigned j = 0; j < DEPTH; j++) begin
                older_d[j][free_idx] = (IDX_W'(j) != free_idx);
            end
            older_d[free_idx] = '0;
        end

        if (flush) valid_d = '0;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + {{(CNT_W-1){1'b0}}, valid_d[i]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            older_q   <= '{default: '0};
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            older_q   <= older_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_tag_q  <= rd_tag_d;
        rs1_tag_q <= rs1_tag_d;
        rs2_tag_q <= rs2_tag_d;
        rs1_val_q <= rs1_val_d;
        rs2_val_q <= rs2_val_d;
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Self-checking bench for rs_multi_cdb: vector table, scoreboard on the issue
// handshake, and hand-written multi-cycle sequences including a NO_WAIT_RS2 instance.
module tb_rs_multi_cdb;

    localparam int DEPTH = 8;
    localparam int TW    = 5;
    localparam int DW    = 32;
    localparam int PW    = 64;
    localparam int NC    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          reset;
    logic          alloc_valid, alloc_ready;
    logic [TW-1:0] alloc_rd_tag, alloc_rs1_tag, alloc_rs2_tag;
    logic          alloc_rs1_rdy, alloc_rs2_rdy;
    logic [DW-1:0] alloc_rs1_val, alloc_rs2_val;
    logic [PW-1:0] alloc_payload;
    logic [NC-1:0] cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_value;
    logic          issue_valid, issue_ready;
    logic [TW-1:0] issue_rd_tag;
    logic [DW-1:0] issue_rs1_val, issue_rs2_val;
    logic [PW-1:0] issue_payload;
    logic          flush;
    logic [CW-1:0] count;

    logic          alloc_valid_n, alloc_ready_n;
    logic [NC-1:0] cdb_valid_n;
    logic          issue_valid_n, issue_ready_n;
    logic [TW-1:0] issue_rd_tag_n;
    logic [DW-1:0] issue_rs1_val_n, issue_rs2_val_n;
    logic [PW-1:0] issue_payload_n;
    logic          flush_n;
    logic [CW-1:0] count_n;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [TW-1:0] rd;
        logic [DW-1:0] v1;
        logic [DW-1:0] v2;
        logic [PW-1:0] pl;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [TW-1:0] rd;
        logic [TW-1:0] t1;
        logic          r1;
        logic [DW-1:0] v1;
        logic [TW-1:0] t2;
        logic          r2;
        logic [DW-1:0] v2;
        logic          cv0;
        logic [TW-1:0] ct0;
        logic [DW-1:0] cval0;
        logic          cv1;
        logic [TW-1:0] ct1;
        logic [DW-1:0] cval1;
        logic [DW-1:0] e1;
        logic [DW-1:0] e2;
    } vec_t;
    vec_t vt[6];

    rs_multi_cdb #(.DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW),
                   .NUM_CDB(NC), .NO_WAIT_RS2(0)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_rd_tag(alloc_rd_tag), .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
        .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
        .alloc_rs1_val(alloc_rs1_val), .alloc_rs2_val(alloc_rs2_val),
        .alloc_payload(alloc_payload),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rd_tag(issue_rd_tag), .issue_rs1_val(issue_rs1_val),
        .issue_rs2_val(issue_rs2_val), .issue_payload(issue_payload),
        .flush(flush), .count(count)
    );

    rs_multi_cdb #(.DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW), .PAYLOAD_W(PW),
                   .NUM_CDB(NC), .NO_WAIT_RS2(1)) dut_nw (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid_n), .alloc_ready(alloc_ready_n),
        .alloc_rd_tag(alloc_rd_tag), .alloc_rs1_tag(alloc_rs1_tag), .alloc_rs2_tag(alloc_rs2_tag),
        .alloc_rs1_rdy(alloc_rs1_rdy), .alloc_rs2_rdy(alloc_rs2_rdy),
        .alloc_rs1_val(alloc_rs1_val), .alloc_rs2_val(alloc_rs2_val),
        .alloc_payload(alloc_payload),
        .cdb_valid(cdb_valid_n), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid_n), .issue_ready(issue_ready_n),
        .issue_rd_tag(issue_rd_tag_n), .issue_rs1_val(issue_rs1_val_n),
        .issue_rs2_val(issue_rs2_val_n), .issue_payload(issue_payload_n),
        .flush(flush_n), .count(count_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Settle, score any handshake on the coming edge, then advance one cycle.
    task automatic step();
        exp_t e;
        #1;
        if (issue_valid && issue_ready) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_issue", 64'(issue_rd_tag), 64'h0);
            end else begin
                e = sbq.pop_front();
                chk("sb_rd_tag",  64'(issue_rd_tag),  64'(e.rd));
                chk("sb_rs1_val", 64'(issue_rs1_val), 64'(e.v1));
                chk("sb_rs2_val", 64'(issue_rs2_val), 64'(e.v2));
                chk("sb_payload", issue_payload,      e.pl);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        alloc_valid_n = 1'b0;
        cdb_valid     = '0;
        cdb_valid_n   = '0;
        issue_ready   = 1'b0;
        issue_ready_n = 1'b0;
        flush         = 1'b0;
        flush_n       = 1'b0;
    endtask

    task automatic drive_alloc(input logic [TW-1:0] rd, input logic [TW-1:0] t1, input logic r1,
                               input logic [DW-1:0] v1, input logic [TW-1:0] t2, input logic r2,
                               input logic [DW-1:0] v2, input logic [PW-1:0] pl);
        alloc_valid   = 1'b1;
        alloc_rd_tag  = rd;
        alloc_rs1_tag = t1;
        alloc_rs1_rdy = r1;
        alloc_rs1_val = v1;
        alloc_rs2_tag = t2;
        alloc_rs2_rdy = r2;
        alloc_rs2_val = v2;
        alloc_payload = pl;
    endtask

    task automatic bcast(input int p, input logic [TW-1:0] tag, input logic [DW-1:0] val);
        cdb_valid[p]          = 1'b1;
        cdb_tag[p*TW +: TW]   = tag;
        cdb_value[p*DW +: DW] = val;
    endtask

    task automatic expect_issue(input logic [TW-1:0] rd, input logic [DW-1:0] v1,
                                input logic [DW-1:0] v2, input logic [PW-1:0] pl);
        exp_t e;
        e.rd = rd; e.v1 = v1; e.v2 = v2; e.pl = pl;
        sbq.push_back(e);
    endtask

    function automatic vec_t mk(input logic [TW-1:0] rd, input logic [TW-1:0] t1, input logic r1,
                                input logic [DW-1:0] v1, input logic [TW-1:0] t2, input logic r2,
                                input logic [DW-1:0] v2, input logic cv0, input logic [TW-1:0] ct0,
                                input logic [DW-1:0] cval0, input logic cv1, input logic [TW-1:0] ct1,
                                input logic [DW-1:0] cval1, input logic [DW-1:0] e1,
                                input logic [DW-1:0] e2);
        vec_t v;
        v.rd = rd; v.t1 = t1; v.r1 = r1; v.v1 = v1; v.t2 = t2; v.r2 = r2; v.v2 = v2;
        v.cv0 = cv0; v.ct0 = ct0; v.cval0 = cval0; v.cv1 = cv1; v.ct1 = ct1; v.cval1 = cval1;
        v.e1 = e1; v.e2 = e2;
        return v;
    endfunction

    initial begin
        logic [PW-1:0] pl;
        logic [TW-1:0] wt;

        vt[0] = mk(5'd3,  5'd0,  1'b0, 32'h10,   5'd0,  1'b0, 32'h20,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20);
        vt[1] = mk(5'd6,  5'd7,  1'b0, 32'hDEAD, 5'd0,  1'b0, 32'h22,
                   1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'h0, 32'h11, 32'h22);
        vt[2] = mk(5'd8,  5'd4,  1'b1, 32'h44,   5'd12, 1'b0, 32'h0,
                   1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'h1234, 32'h44, 32'h1234);
        vt[3] = mk(5'd13, 5'd13, 1'b0, 32'h0,    5'd13, 1'b0, 32'h0,
                   1'b1, 5'd13, 32'hA0, 1'b1, 5'd13, 32'hB0, 32'hA0, 32'hA0);
        vt[4] = mk(5'd20, 5'd14, 1'b0, 32'h0,    5'd15, 1'b0, 32'h0,
                   1'b1, 5'd15, 32'hC0, 1'b1, 5'd14, 32'hC1, 32'hC1, 32'hC0);
        vt[5] = mk(5'd31, 5'd0,  1'b0, 32'hFFFF_FFFF, 5'd0, 1'b1, 32'h0,
                   1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF, 32'h0);

        reset = 1'b1;
        idle();
        cdb_tag = '0;
        cdb_value = '0;
        drive_alloc(5'd1, 5'd0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 64'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alloc_ready", 64'(alloc_ready), 64'h0);
        chk("rst_issue_valid", 64'(issue_valid), 64'h0);
        chk("rst_count",       64'(count),       64'h0);
        alloc_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("post_rst_alloc_ready", 64'(alloc_ready), 64'h1);
        chk("post_rst_issue_valid", 64'(issue_valid), 64'h0);

        // Single-entry vectors, including alloc-cycle CDB bypass cases
        for (int i = 0; i < 6; i++) begin
            pl = {32'hCAFE_0000, 32'(i)};
            drive_alloc(vt[i].rd, vt[i].t1, vt[i].r1, vt[i].v1, vt[i].t2, vt[i].r2, vt[i].v2, pl);
            if (vt[i].cv0) bcast(0, vt[i].ct0, vt[i].cval0);
            if (vt[i].cv1) bcast(1, vt[i].ct1, vt[i].cval1);
            expect_issue(vt[i].rd, vt[i].e1, vt[i].e2, pl);
            step();
            idle();
            chk("tbl_count1",      64'(count),       64'h1);
            chk("tbl_issue_valid", 64'(issue_valid), 64'h1);
            issue_ready = 1'b1;
            step();
            issue_ready = 1'b0;
            chk("tbl_count0", 64'(count), 64'h0);
        end

        // Wakeup of both operands from one port; woken entry not issuable same cycle
        pl = 64'hB;
        drive_alloc(5'd4, 5'd5, 1'b0, 32'h0, 5'd5, 1'b0, 32'h0, pl);
        step();
        idle();
        chk("b_wait_valid", 64'(issue_valid), 64'h0);
        bcast(1, 5'd5, 32'hAB);
        #1;
        chk("b_no_same_cycle_issue", 64'(issue_valid), 64'h0);
        expect_issue(5'd4, 32'hAB, 32'hAB, pl);
        step();
        idle();
        chk("b_woken_valid", 64'(issue_valid), 64'h1);
        issue_ready = 1'b1;
        step();
        idle();
        chk("b_count0", 64'(count), 64'h0);

        // Two ports match one operand: port 0 wins; rs2 woken later
        pl = 64'h9;
        drive_alloc(5'd9, 5'd6, 1'b0, 32'h0, 5'd8, 1'b0, 32'h0, pl);
        step();
        idle();
        bcast(0, 5'd6, 32'h60);
        bcast(1, 5'd6, 32'h61);
        step();
        idle();
        chk("mp_rs2_pending", 64'(issue_valid), 64'h0);
        bcast(1, 5'd8, 32'h88);
        expect_issue(5'd9, 32'h60, 32'h88, pl);
        step();
        idle();
        issue_ready = 1'b1;
        step();
        idle();
        chk("mp_count0", 64'(count), 64'h0);

        // Simultaneous alloc and issue keep count steady
        drive_alloc(5'd10, 5'd0, 1'b1, 32'h1, 5'd0, 1'b1, 32'h2, 64'hD);
        expect_issue(5'd10, 32'h1, 32'h2, 64'hD);
        step();
        drive_alloc(5'd11, 5'd0, 1'b1, 32'h3, 5'd0, 1'b1, 32'h4, 64'hE);
        expect_issue(5'd11, 32'h3, 32'h4, 64'hE);
        issue_ready = 1'b1;
        step();
        alloc_valid = 1'b0;
        chk("sim_count1", 64'(count),       64'h1);
        chk("sim_valid",  64'(issue_valid), 64'h1);
        step();
        idle();
        chk("sim_count0", 64'(count), 64'h0);

        // Stall for 3 cycles, then flush (alloc and issue in the flush cycle ignored)
        drive_alloc(5'd12, 5'd0, 1'b1, 32'h5, 5'd0, 1'b1, 32'h6, 64'hF);
        step();
        idle();
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_valid",  64'(issue_valid),  64'h1);
            chk("stall_rd_tag", 64'(issue_rd_tag), 64'd12);
            chk("stall_count",  64'(count),        64'h1);
        end
        flush = 1'b1;
        issue_ready = 1'b1;
        drive_alloc(5'd13, 5'd0, 1'b1, 32'h7, 5'd0, 1'b1, 32'h8, 64'h10);
        #1;
        chk("flush_gate_valid", 64'(issue_valid), 64'h0);
        step();
        idle();
        chk("flush_count",       64'(count),       64'h0);
        chk("flush_issue_valid", 64'(issue_valid), 64'h0);

        // Reset overrides alloc and issue in the same cycle
        drive_alloc(5'd14, 5'd0, 1'b1, 32'h9, 5'd0, 1'b1, 32'hA, 64'h11);
        step();
        reset = 1'b1;
        issue_ready = 1'b1;
        step();
        reset = 1'b0;
        idle();
        chk("rst_ovr_count",       64'(count),       64'h0);
        chk("rst_ovr_issue_valid", 64'(issue_valid), 64'h0);

        // Fill, wake in reverse, drain in allocation order; three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                pl = {32'(r), 32'(i)};
                drive_alloc(TW'(i + 1), TW'(r * 8 + i + 1), 1'b0, 32'h0,
                            5'd0, 1'b1, 32'(r * 16 + i), pl);
                expect_issue(TW'(i + 1), 32'h1000 + 32'(r * 256 + i), 32'(r * 16 + i), pl);
                step();
            end
            alloc_valid = 1'b0;
            chk("full_alloc_ready", 64'(alloc_ready), 64'h0);
            chk("full_count",       64'(count),       64'(DEPTH));
            drive_alloc(5'd30, 5'd0, 1'b1, 32'h0, 5'd0, 1'b1, 32'h0, 64'h0);
            step();
            alloc_valid = 1'b0;
            chk("full_reject_count", 64'(count), 64'(DEPTH));
            for (int i = DEPTH - 1; i >= 0; i--) begin
                wt = TW'(r * 8 + i + 1);
                bcast(i % 2, wt, 32'h1000 + 32'(r * 256 + i));
                step();
                cdb_valid = '0;
            end
            issue_ready = 1'b1;
            for (int k = 0; k < 4 * DEPTH && sbq.size() != 0; k++) step();
            issue_ready = 1'b0;
            chk("drain_sb_empty", 64'(sbq.size()), 64'h0);
            chk("drain_count",    64'(count),      64'h0);
        end

        // NO_WAIT_RS2 instance issues with rs2 pending; normal instance waits
        drive_alloc(5'd17, 5'd0, 1'b1, 32'h55, 5'd9, 1'b0, 32'h0, 64'h17);
        alloc_valid_n = 1'b1;
        step();
        idle();
        chk("nw_issue_valid",  64'(issue_valid_n),   64'h1);
        chk("nw_rd_tag",       64'(issue_rd_tag_n),  64'd17);
        chk("nw_rs1_val",      64'(issue_rs1_val_n), 64'h55);
        chk("nw_normal_waits", 64'(issue_valid),     64'h0);
        issue_ready_n = 1'b1;
        step();
        idle();
        chk("nw_count0", 64'(count_n), 64'h0);
        bcast(0, 5'd9, 32'h99);
        cdb_valid_n = cdb_valid;
        expect_issue(5'd17, 32'h55, 32'h99, 64'h17);
        step();
        idle();
        chk("nw_late_bcast_count", 64'(count_n),       64'h0);
        chk("nw_late_bcast_valid", 64'(issue_valid_n), 64'h0);
        chk("nw_normal_woken",     64'(issue_valid),   64'h1);
        issue_ready = 1'b1;
        step();
        idle();
        chk("nw_normal_count0", 64'(count),      64'h0);
        chk("sb_drained",       64'(sbq.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_multi_cdb.md
RS_MULTI_CDB -- requirements
Module: rs_multi_cdb

Interface
REQ-001 Parameters (name, default, meaning):
- DEPTH, 8: entries.
- TAG_W, 5: ROB tag width; tag 0 = no dependency.
- DATA_W, 32: operand width.
- PAYLOAD_W, 64: opaque instruction payload width.
- NUM_CDB, 2: broadcast ports.
- NO_WAIT_RS2, 0: 1 = issue without rs2 ready.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high.
- alloc_valid, in, 1: allocation request.
- alloc_ready, out, 1: free entry available.
- alloc_rd_tag, in, TAG_W: destination tag.
- alloc_rs1_tag / alloc_rs2_tag, in, TAG_W: source tags.
- alloc_rs1_rdy / alloc_rs2_rdy, in, 1: source value already valid.
- alloc_rs1_val / alloc_rs2_val, in, DATA_W: regfile/ROB values.
- alloc_payload, in, PAYLOAD_W: decoded instruction.
- cdb_valid, in, NUM_CDB: per-port broadcast valid.
- cdb_tag, in, NUM_CDB*TAG_W: port p at bits [p*TAG_W +: TAG_W].
- cdb_value, in, NUM_CDB*DATA_W: port p at bits [p*DATA_W +: DATA_W].
- issue_valid, out, 1: a ready entry is presented.
- issue_ready, in, 1: execution unit accepts (not stalled).
- issue_rd_tag, out, TAG_W; issue_rs1_val / issue_rs2_val, out, DATA_W; issue_payload, out, PAYLOAD_W: selected entry fields.
- flush, in, 1: squash all entries.
- count, out, $clog2(DEPTH+1): valid entries.

Function
REQ-003 Entry state: valid, rd_tag, rs1/rs2 tag, ready bit, value, payload, plus age relation against every other entry.
REQ-004 Operand ready at alloc = alloc_rsX_rdy OR alloc_rsX_tag==0 OR same-cycle CDB match (alloc bypass); CDB value stored on bypass.
REQ-005 Allocation fires when alloc_valid && alloc_ready && !flush; writes lowest-index free entry; entry becomes youngest.
REQ-006 alloc_ready = (count < DEPTH) && !reset; depends only on registered state, never on same-cycle issue.
REQ-007 Wakeup: each valid entry, each non-ready operand, each port p: cdb_valid[p] && tag match -> capture cdb_value[p] and set ready at the edge.
REQ-008 rs1 and rs2 wake independently in the same cycle, including both from one port when tags are equal.
REQ-009 Multiple ports matching one operand: lowest port index wins.
REQ-010 Entry issuable when valid && rs1_ready && (rs2_ready || NO_WAIT_RS2).
REQ-011 issue_valid = any issuable entry && !flush && !reset; combinational from registered state.
REQ-012 No same-cycle CDB-to-issue path: a woken entry issues no earlier than the next cycle.
REQ-013 Selection: oldest issuable entry by allocation order, correct across unlimited allocations (no birthday counter wrap or saturation error).
REQ-014 issue_* fields = selected entry's registered fields; undefined-but-stable-free when issue_valid=0.
REQ-015 Issue handshake: issue_valid && issue_ready -> selected entry invalidated at the edge; slot allocatable next cycle.
REQ-016 issue_valid && !issue_ready: entry retained; selection may change only if an older entry becomes issuable.
REQ-017 Simultaneous alloc + issue: both take effect; count unchanged; new entry never uses the slot being freed that cycle.
REQ-018 flush: all entries invalidated at the edge; alloc, wakeup and issue that cycle ignored; count=0 next cycle.
REQ-019 count = popcount(valid), registered.

Reset
REQ-020 reset high at an edge: all entries invalid, age state cleared, count=0.
REQ-021 While reset high: issue_valid=0, alloc_ready=0; after deassertion alloc_ready=1, issue_valid=0.
REQ-022 Reset overrides flush, alloc, wakeup and issue in the same cycle.

Verification
REQ-023 Alloc A (rd 3, rs1 tag 0, rs2 tag 0) -> next cycle issue_valid=1, issue_rd_tag=3; issue_ready=1 -> count 1->0.
REQ-024 Alloc B (rs1 tag 5, rs2 tag 5, not ready); port1 broadcasts tag 5 value 0xAB -> next cycle both operands 0xAB and issue_valid=1.
REQ-025 Alloc C (rs1 tag 7) while port0 broadcasts tag 7 value 0x11 in the same cycle -> C issues next cycle with rs1=0x11.
REQ-026 Fill DEPTH entries with unresolved tags -> alloc_ready=0, count=DEPTH; wake entries in reverse order -> issue order equals allocation order; repeat for 3*DEPTH allocations to exercise age wrap.
REQ-027 issue_ready=0 held 3 cycles with ready entry -> issue_valid stays 1 and entry retained; flush asserted -> count=0, issue_valid=0 next cycle.
REQ-028 NO_WAIT_RS2=1 instance: entry with rs1 ready, rs2 tag 9 pending -> issues next cycle; later broadcast of tag 9 has no effect.
